codec_cfg_sched: RTL and testbench
==================================

CODEC_CFG_SCHED -- requirements
Module: codec_cfg_sched

Interface
REQ-001 Parameter DEV_ADDR, 8'h34, I2C device write address placed in i2c_word[23:16].
REQ-002 Parameter GAP_CYCLES, 64, minimum idle clk cycles between i2c_done and the next i2c_go.
REQ-003 Parameter TIMEOUT, 4096, clk cycles after i2c_go before a missing i2c_done is treated as NACK.
REQ-004 Parameter MAX_RETRY, 3, maximum reissues of one word after NACK (RETRY_EN only).
REQ-005 clk  input  1  system clock, 50 MHz.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 reinit  input  1  one-cycle pulse; reruns the init table.
REQ-008 usr_req  input  1  level; runtime register write request, held until usr_ack.
REQ-009 usr_addr  input  7  codec register address for the runtime write.
REQ-010 usr_data  input  9  codec register data for the runtime write.
REQ-011 usr_ack  output  1  one-cycle pulse when the user write completes, with or without ACK.
REQ-012 i2c_go  output  1  one-cycle start pulse to the shared I2C byte-write engine.
REQ-013 i2c_word  output  24  {DEV_ADDR, reg_addr[6:0], reg_data[8:0]}; stable from i2c_go until i2c_done.
REQ-014 i2c_done  input  1  one-cycle pulse from the engine at end of stop condition.
REQ-015 i2c_nack  input  1  valid only while i2c_done=1; 1 = any of the three ACK slots was high.
REQ-016 init_done  output  1  high once every init entry has been issued.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 err  output  1  sticky; set on any word abandoned after NACK or timeout.
REQ-019 nack_cnt  output  8  saturating count of NACK/timeout events.

Function
REQ-020 The init table SHALL hold 9 words in order: 0C00, 0EC2, 0838, 1000, 0017, 0217, 0479, 0679, 1201 (hex, {addr,data}).
REQ-021 FSM states SHALL be IDLE, GAP, ISSUE, WAIT, CHECK.
REQ-022 IDLE: if init pending -> GAP; else if usr_req -> latch usr_addr/usr_data, GAP; else stay.
REQ-023 GAP SHALL count GAP_CYCLES clk cycles, then go to ISSUE.
REQ-024 ISSUE SHALL load i2c_word, assert i2c_go for exactly one cycle, clear the timeout counter, and go to WAIT.
REQ-025 WAIT SHALL go to CHECK on i2c_done, or on timeout counter reaching TIMEOUT-1 (forced NACK).
REQ-026 CHECK on ACK: an init word advances the index (after entry 8: init_done=1); a user word pulses usr_ack; then -> IDLE.
REQ-027 CHECK on NACK SHALL increment nack_cnt (saturating at 255).
REQ-028 Init has strict priority; usr_req asserted during init SHALL wait, unlatched, until init_done=1.
REQ-029 reinit seen in any state SHALL set a pending flag; at the next IDLE, init_done clears and the index resets to 0; reinit wins over a simultaneous usr_req.
REQ-030 Latency from usr_req in IDLE (init complete) to i2c_go SHALL be GAP_CYCLES+2 cycles.
REQ-031 i2c_done arriving outside WAIT SHALL be ignored.

Reset
REQ-032 reset SHALL asynchronously force IDLE with init pending, index 0, i2c_go=0, i2c_word=0, usr_ack=0, init_done=0, busy=0, err=0, nack_cnt=0.
REQ-033 Deassertion of reset SHALL start the init sequence without further stimulus; a reset during a transfer discards that word.

Configuration
REQ-034 Macro CODEC_CFG_SCHED_RETRY_EN defined: on NACK, if the retry count < MAX_RETRY, the count increments and the FSM -> GAP to reissue the same word; otherwise err=1 and the word is abandoned as in REQ-026 (usr_ack still pulses); the retry count clears on every new word.
REQ-035 Macro CODEC_CFG_SCHED_RETRY_EN undefined: any NACK sets err=1 and the word is abandoned immediately with no reissue.

Verification
REQ-036 Reset release, engine always ACKs -> 9 i2c_go pulses carrying words 340C00 ... 341201 in order, each GAP_CYCLES apart; init_done=1; err=0.
REQ-037 After init, usr_req with addr 02, data 079 -> i2c_word=340479, one usr_ack pulse, busy low afterwards.
REQ-038 NACK on the 3rd init word with RETRY_EN -> word 340838 issued 4 times, err=1, nack_cnt=4, sequence continues with 341000; without RETRY_EN -> issued once, nack_cnt=1.
REQ-039 Engine never returns i2c_done -> forced NACK after TIMEOUT cycles, nack_cnt increments, FSM proceeds.
REQ-040 usr_req held during init plus reinit pulse mid-init -> init completes, restarts from 340C00, user write issued only after the second init_done.
REQ-041 reset asserted during WAIT -> all outputs at reset values within the same cycle; the init sequence restarts from entry 0.

Source files
------------

// File: rtl/codec_cfg_sched_if.sv
// Handshake bundle between the codec config scheduler, the user write port
// and the shared I2C byte-write engine. The master modport is the scheduler side.
interface codec_cfg_sched_if;
  logic        usr_req;
  logic [6:0]  usr_addr;
  logic [8:0]  usr_data;
  logic        usr_ack;
  logic        i2c_go;
  logic [23:0] i2c_word;
  logic        i2c_done;
  logic        i2c_nack;

  modport master (
    input  usr_req, usr_addr, usr_data, i2c_done, i2c_nack,
    output usr_ack, i2c_go, i2c_word
  );

  modport slave (
    output usr_req, usr_addr, usr_data, i2c_done, i2c_nack,
    input  usr_ack, i2c_go, i2c_word
  );
endinterface

// File: rtl/codec_cfg_sched.sv
// Codec configuration scheduler: replays a 9-entry init table after reset or
// reinit, then serves runtime register writes, one word at a time, through a
// shared I2C byte-write engine with a minimum idle gap and a done timeout.
// Optional feature macro CODEC_CFG_SCHED_RETRY_EN: reissue a NACKed word up
// to MAX_RETRY times before abandoning it.
module codec_cfg_sched #(
  parameter logic [7:0]  DEV_ADDR   = 8'h34,
  parameter int unsigned GAP_CYCLES = 64,
  parameter int unsigned TIMEOUT    = 4096,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reinit,
  codec_cfg_sched_if.master bus,
  output logic              init_done,
  output logic              busy,
  output logic              err,
  output logic [7:0]        nack_cnt
);

  localparam int unsigned CNT_MAX  = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
  localparam int unsigned RTRY_W   = $clog2(MAX_RETRY + 2);
  localparam int unsigned IDX_W    = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(8);

`ifdef CODEC_CFG_SCHED_RETRY_EN
  localparam bit RETRY_ON = 1'b1;
`else
  localparam bit RETRY_ON = 1'b0;
`endif

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] GAP   = 3'd1;
  localparam logic [2:0] ISSUE = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] CHECK = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RTRY_W-1:0] retry_q, retry_d;
  logic              pend_q, pend_d;
  logic              init_act_q, init_act_d;
  logic              is_usr_q, is_usr_d;
  logic              nack_q, nack_d;
  logic [6:0]        uaddr_q, uaddr_d;
  logic [8:0]        udata_q, udata_d;
  logic              go_q, go_d;
  logic [23:0]       word_q, word_d;
  logic              ack_q, ack_d;
  logic              init_done_q, init_done_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [7:0]        nack_cnt_q, nack_cnt_d;
  logic              word_end;

  // Init table entries as {reg_addr[6:0], reg_data[8:0]}
  function automatic logic [15:0] init_entry(input logic [IDX_W-1:0] i);
    case (i)
      IDX_W'(0): init_entry = 16'h0C00;
      IDX_W'(1): init_entry = 16'h0EC2;
      IDX_W'(2): init_entry = 16'h0838;
      IDX_W'(3): init_entry = 16'h1000;
      IDX_W'(4): init_entry = 16'h0017;
      IDX_W'(5): init_entry = 16'h0217;
      IDX_W'(6): init_entry = 16'h0479;
      IDX_W'(7): init_entry = 16'h0679;
      IDX_W'(8): init_entry = 16'h1201;
      default:   init_entry = 16'h0000;
    endcase
  endfunction

  // Next-state and output decode; a finished or abandoned word is closed out below the case
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = '0;
    retry_d     = retry_q;
    pend_d      = pend_q | reinit;
    init_act_d  = init_act_q;
    is_usr_d    = is_usr_q;
    nack_d      = nack_q;
    uaddr_d     = uaddr_q;
    udata_d     = udata_q;
    go_d        = 1'b0;
    word_d      = word_q;
    ack_d       = 1'b0;
    init_done_d = init_done_q;
    err_d       = err_q;
    nack_cnt_d  = nack_cnt_q;
    word_end    = 1'b0;

    case (state_q)
      IDLE: begin
        if (pend_q || reinit) begin
          pend_d      = 1'b0;
          idx_d       = '0;
          init_done_d = 1'b0;
          init_act_d  = 1'b1;
          is_usr_d    = 1'b0;
          retry_d     = '0;
          state_d     = GAP;
        end else if (init_act_q) begin
          is_usr_d = 1'b0;
          retry_d  = '0;
          state_d  = GAP;
        end else if (bus.usr_req && !ack_q) begin
          // ack_q blocks the request still held during the ack cycle
          uaddr_d  = bus.usr_addr;
          udata_d  = bus.usr_data;
          is_usr_d = 1'b1;
          retry_d  = '0;
          state_d  = GAP;
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) state_d = ISSUE;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      ISSUE: begin
        go_d    = 1'b1;
        word_d  = {DEV_ADDR, is_usr_q ? {uaddr_q, udata_q} : init_entry(idx_q)};
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.i2c_done) begin
          nack_d  = bus.i2c_nack;
          state_d = CHECK;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          nack_d  = 1'b1;
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CHECK: begin
        if (nack_q) begin
          if (nack_cnt_q != 8'hFF) nack_cnt_d = nack_cnt_q + 8'd1;
          if (RETRY_ON && (retry_q < RTRY_W'(MAX_RETRY))) begin
            retry_d = retry_q + RTRY_W'(1);
            state_d = GAP;
          end else begin
            err_d    = 1'b1;
            word_end = 1'b1;
          end
        end else begin
          word_end = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (word_end) begin
      state_d = IDLE;
      if (is_usr_q) begin
        ack_d = 1'b1;
      end else if (idx_q == LAST_IDX) begin
        init_done_d = 1'b1;
        init_act_d  = 1'b0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset leaves an init run pending
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      retry_q     <= '0;
      pend_q      <= 1'b1;
      init_act_q  <= 1'b0;
      is_usr_q    <= 1'b0;
      nack_q      <= 1'b0;
      uaddr_q     <= '0;
      udata_q     <= '0;
      go_q        <= 1'b0;
      word_q      <= '0;
      ack_q       <= 1'b0;
      init_done_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      nack_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pend_q      <= pend_d;
      init_act_q  <= init_act_d;
      is_usr_q    <= is_usr_d;
      nack_q      <= nack_d;
      uaddr_q     <= uaddr_d;
      udata_q     <= udata_d;
      go_q        <= go_d;
      word_q      <= word_d;
      ack_q       <= ack_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      nack_cnt_q  <= nack_cnt_d;
    end
  end

  assign bus.i2c_go   = go_q;
  assign bus.i2c_word = word_q;
  assign bus.usr_ack  = ack_q;
  assign init_done    = init_done_q;
  assign busy         = busy_q;
  assign err          = err_q;
  assign nack_cnt     = nack_cnt_q;

endmodule

// File: tb/tb_codec_cfg_sched.sv
`timescale 1ns/1ps
// Bench for codec_cfg_sched: expected I2C words are queued as stimulus is
// applied and popped on every i2c_go; a reactive engine model answers each go.
module tb_codec_cfg_sched;
  localparam int unsigned GAP     = 8;
  localparam int unsigned TO      = 64;
  localparam int unsigned MAXR    = 3;
  localparam int unsigned ENG_LAT = 5;
`ifdef CODEC_CFG_SCHED_RETRY_EN
  localparam int unsigned NACK_ISSUES = MAXR + 1;
`else
  localparam int unsigned NACK_ISSUES = 1;
`endif

  typedef struct {
    logic [6:0]  addr;
    logic [8:0]  data;
    bit          nack;
    logic [23:0] word;
    bit          err_after;
  } uvec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       reinit;
  logic       init_done;
  logic       busy;
  logic       err;
  logic [7:0] nack_cnt;

  int          checks = 0;
  int          errors = 0;
  longint      cyc = 0;
  longint      done_cyc = 0;
  bit          done_seen = 1'b0;
  bit          prev_go = 1'b0;
  bit          mute = 1'b0;
  int          go_cnt = 0;
  int          eng_cnt = 0;
  logic [23:0] eng_word = '0;
  logic [23:0] nack_word = 24'hFFFFFF;
  logic [23:0] mon_w;
  logic [23:0] exp_q[$];
  logic [15:0] init_tbl [9] = '{16'h0C00, 16'h0EC2, 16'h0838, 16'h1000, 16'h0017,
                                16'h0217, 16'h0479, 16'h0679, 16'h1201};

  codec_cfg_sched_if bus ();

  codec_cfg_sched #(
    .DEV_ADDR  (8'h34),
    .GAP_CYCLES(GAP),
    .TIMEOUT   (TO),
    .MAX_RETRY (MAXR)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .reinit   (reinit),
    .bus      (bus),
    .init_done(init_done),
    .busy     (busy),
    .err      (err),
    .nack_cnt (nack_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Engine model: answers each go after ENG_LAT cycles, NACKing nack_word
  always @(negedge clk) begin
    if (reset) begin
      eng_cnt = 0;
      bus.i2c_done = 1'b0;
      bus.i2c_nack = 1'b0;
      done_seen = 1'b0;
    end else begin
      bus.i2c_done = 1'b0;
      bus.i2c_nack = 1'b0;
      if (bus.i2c_go && !mute) begin
        eng_cnt  = ENG_LAT;
        eng_word = bus.i2c_word;
      end else if (eng_cnt != 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          bus.i2c_done = 1'b1;
          bus.i2c_nack = (eng_word == nack_word);
          done_cyc  = cyc;
          done_seen = 1'b1;
          chk("word_stable", 32'(bus.i2c_word), 32'(eng_word));
        end
      end
    end
  end

  // Scoreboard monitor: every go pops one expected word
  always @(negedge clk) begin
    if (reset) begin
      prev_go = 1'b0;
    end else begin
      if (bus.i2c_go) begin
        go_cnt++;
        chk("go_single_cycle", 32'(prev_go), 32'd0);
        if (done_seen) chk("gap_idle", 32'((cyc - done_cyc) > longint'(GAP)), 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra_word: got %06h required none", bus.i2c_word);
        end else begin
          mon_w = exp_q.pop_front();
          chk("sb_word", 32'(bus.i2c_word), 32'(mon_w));
        end
      end
      prev_go = bus.i2c_go;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_init(input int nack_idx, input int reps);
    for (int i = 0; i < 9; i++)
      repeat ((i == nack_idx) ? reps : 1) exp_q.push_back({8'h34, init_tbl[i]});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    reinit = 1'b0;
    bus.usr_req = 1'b0;
    bus.usr_addr = '0;
    bus.usr_data = '0;
    mute = 1'b0;
    nack_word = 24'hFFFFFF;
    tick();
    tick();
    exp_q.delete();
  endtask

  task automatic wait_init(input string name);
    int n = 0;
    while (init_done !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    chk(name, 32'(init_done), 32'd1);
  endtask

  task automatic wait_gos(input int base, input int target);
    int n = 0;
    while ((go_cnt - base) < target && n < 3000) begin
      tick();
      n++;
    end
    chk("go_reached", 32'(go_cnt - base), 32'(target));
  endtask

  initial begin
    uvec_t tbl [4];
    int    go0;
    int    lat;
    int    acks;
    int    n;
    int    gos;
    int    exp_nack;
    logic  idn;

    tbl[0] = '{7'h02, 9'h079, 1'b0, 24'h340479, 1'b0};
    tbl[1] = '{7'h7F, 9'h1FF, 1'b0, 24'h34FFFF, 1'b0};
    tbl[2] = '{7'h00, 9'h000, 1'b0, 24'h340000, 1'b0};
    tbl[3] = '{7'h0A, 9'h155, 1'b1, 24'h341555, 1'b1};

    // Reset values
    do_reset();
    chk("rst_go", 32'(bus.i2c_go), 32'd0);
    chk("rst_word", 32'(bus.i2c_word), 32'd0);
    chk("rst_ack", 32'(bus.usr_ack), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_nack_cnt", 32'(nack_cnt), 32'd0);

    // Init runs by itself after reset release, engine always ACKs
    push_init(-1, 1);
    go0 = go_cnt;
    reset = 1'b0;
    tick();
    chk("busy_after_release", 32'(busy), 32'd1);
    wait_init("init_done");
    chk("init_go_count", 32'(go_cnt - go0), 32'd9);
    chk("init_err", 32'(err), 32'd0);
    chk("init_nack_cnt", 32'(nack_cnt), 32'd0);
    chk("init_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("init_idle", 32'(busy), 32'd0);

    // Table-driven user writes
    exp_nack = 0;
    foreach (tbl[i]) begin
      nack_word = tbl[i].nack ? tbl[i].word : 24'hFFFFFF;
      repeat (tbl[i].nack ? NACK_ISSUES : 1) exp_q.push_back(tbl[i].word);
      if (tbl[i].nack) exp_nack += int'(NACK_ISSUES);
      go0 = go_cnt;
      bus.usr_addr = tbl[i].addr;
      bus.usr_data = tbl[i].data;
      bus.usr_req  = 1'b1;
      lat = 0;
      while (go_cnt == go0 && lat < 1000) begin
        tick();
        lat++;
      end
      chk("usr_latency", 32'(lat), 32'(GAP + 2));
      acks = 0;
      n = 0;
      while (acks == 0 && n < 2000) begin
        tick();
        n++;
        if (bus.usr_ack) begin
          acks++;
          bus.usr_req = 1'b0;
        end
      end
      bus.usr_req = 1'b0;
      repeat (GAP + 6) begin
        tick();
        if (bus.usr_ack) acks++;
      end
      chk("usr_ack_pulses", 32'(acks), 32'd1);
      chk("usr_busy_after", 32'(busy), 32'd0);
      chk("usr_nack_cnt", 32'(nack_cnt), 32'(exp_nack));
      chk("usr_err", 32'(err), 32'(tbl[i].err_after));
      chk("usr_sb_empty", 32'(exp_q.size()), 32'd0);
    end

    // NACK on the third init word
    do_reset();
    nack_word = 24'h340838;
    push_init(2, int'(NACK_ISSUES));
    go0 = go_cnt;
    reset = 1'b0;
    wait_init("nack_init_done");
    chk("nack_go_count", 32'(go_cnt - go0), 32'(8 + NACK_ISSUES));
    chk("nack_nack_cnt", 32'(nack_cnt), 32'(NACK_ISSUES));
    chk("nack_err", 32'(err), 32'd1);
    chk("nack_sb_empty", 32'(exp_q.size()), 32'd0);

    // Engine never answers: forced NACK after TIMEOUT cycles
    do_reset();
    push_init(-1, 1);
    reset = 1'b0;
    wait_init("to_init_done");
    chk("to_err_before", 32'(err), 32'd0);
    mute = 1'b1;
    repeat (NACK_ISSUES) exp_q.push_back(24'h3422AA);
    bus.usr_addr = 7'h11;
    bus.usr_data = 9'h0AA;
    bus.usr_req  = 1'b1;
    acks = 0;
    n = 0;
    while (acks == 0 && n < 5000) begin
      tick();
      n++;
      if (bus.usr_ack) begin
        acks++;
        bus.usr_req = 1'b0;
      end
    end
    bus.usr_req = 1'b0;
    chk("to_ack", 32'(acks), 32'd1);
    chk("to_cycles", 32'(n), 32'(NACK_ISSUES * (GAP + TO + 2) + 1));
    chk("to_nack_cnt", 32'(nack_cnt), 32'(NACK_ISSUES));
    chk("to_err", 32'(err), 32'd1);
    chk("to_sb_empty", 32'(exp_q.size()), 32'd0);
    mute = 1'b0;
    repeat (4) tick();

    // usr_req held through init, reinit pulsed mid-init
    do_reset();
    bus.usr_addr = 7'h05;
    bus.usr_data = 9'h033;
    bus.usr_req  = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back({8'h34, init_tbl[i]});
    go0 = go_cnt;
    reset = 1'b0;
    wait_gos(go0, 3);
    tick();
    reinit = 1'b1;
    tick();
    reinit = 1'b0;
    push_init(-1, 1);
    exp_q.push_back(24'h340A33);
    acks = 0;
    n = 0;
    gos = 0;
    idn = 1'b0;
    while (acks == 0 && n < 5000) begin
      tick();
      n++;
      if (bus.usr_ack) begin
        acks++;
        gos = go_cnt - go0;
        idn = init_done;
        bus.usr_req = 1'b0;
      end
    end
    bus.usr_req = 1'b0;
    chk("reinit_ack", 32'(acks), 32'd1);
    chk("reinit_gos_at_ack", 32'(gos), 32'd13);
    chk("reinit_init_done", 32'(idn), 32'd1);
    chk("reinit_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset asserted while a word is in flight
    do_reset();
    push_init(-1, 1);
    go0 = go_cnt;
    reset = 1'b0;
    wait_gos(go0, 2);
    tick();
    reset = 1'b1;
    #1;
    chk("wrst_go", 32'(bus.i2c_go), 32'd0);
    chk("wrst_word", 32'(bus.i2c_word), 32'd0);
    chk("wrst_ack", 32'(bus.usr_ack), 32'd0);
    chk("wrst_init_done", 32'(init_done), 32'd0);
    chk("wrst_busy", 32'(busy), 32'd0);
    chk("wrst_err", 32'(err), 32'd0);
    chk("wrst_nack_cnt", 32'(nack_cnt), 32'd0);
    exp_q.delete();
    tick();
    tick();
    push_init(-1, 1);
    go0 = go_cnt;
    reset = 1'b0;
    wait_init("wrst_init_done_again");
    chk("wrst_go_count", 32'(go_cnt - go0), 32'd9);
    chk("wrst_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
